// File: rtl/idli_alu_if.sv
// Operation offer/accept channel and nibble write-back port of the nibble-serial ALU.
// The initiator/register-file side uses the master modport; the ALU uses slave.
interface idli_alu_if;
    logic        i_alu_op_vld;
    logic [2:0]  i_alu_op;
    logic [2:0]  i_alu_dst;
    logic [3:0]  i_alu_b_data;
    logic [3:0]  i_alu_c_data;
    logic        o_alu_op_rdy;
    logic [2:0]  o_alu_a;
    logic        o_alu_a_vld;
    logic [3:0]  o_alu_a_data;
    logic        o_alu_done;
    logic [15:0] o_alu_result;
    logic        o_alu_flag_z;
    logic        o_alu_flag_c;

    modport master (
        output i_alu_op_vld, i_alu_op, i_alu_dst, i_alu_b_data, i_alu_c_data,
        input  o_alu_op_rdy, o_alu_a, o_alu_a_vld, o_alu_a_data,
        input  o_alu_done, o_alu_result, o_alu_flag_z, o_alu_flag_c
    );

    modport slave (
        input  i_alu_op_vld, i_alu_op, i_alu_dst, i_alu_b_data, i_alu_c_data,
        output o_alu_op_rdy, o_alu_a, o_alu_a_vld, o_alu_a_data,
        output o_alu_done, o_alu_result, o_alu_flag_z, o_alu_flag_c
    );
endinterface

// File: rtl/idli_alu_m.sv
// Nibble-serial 16-bit ALU: one op spans four phases, LSB nibble first,
// writing each result nibble back in the same cycle its operands are read.
//
// state | meaning
// IDLE  | no op in flight beyond a phase-0 acceptance this cycle
// BUSY  | accepted op is in phases 1..3
module idli_alu_m (
    input  logic         i_alu_gck,
    input  logic         i_alu_rst,
    idli_alu_if.slave    alu
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_ANDN = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_CMP  = 3'd7;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_phase;
    logic [2:0]  r_op;
    logic [2:0]  r_dst;
    logic        r_carry;
    logic        r_prev;
    logic        r_zacc;
    logic [15:0] r_result;
    logic        r_flag_z;
    logic        r_flag_c;
    logic        r_done;

    logic        w_ph0;
    logic        w_accept;
    logic        w_active;
    logic [2:0]  w_op;
    logic [2:0]  w_dst;
    logic        w_inv;
    logic        w_arith;
    logic        w_cin;
    logic [3:0]  w_c_eff;
    logic [4:0]  w_sum;
    logic        w_prev;
    logic [3:0]  w_nib;
    logic        w_zacc;
    logic        w_cout;

    assign w_ph0    = (r_phase == 2'd0);
    assign w_accept = alu.i_alu_op_vld & w_ph0 & ~i_alu_rst;
    assign w_active = w_accept | (r_state == BUSY);

    // In phase 0 the op is still on the offer lines; later phases use the latched copy.
    assign w_op  = w_ph0 ? alu.i_alu_op  : r_op;
    assign w_dst = w_ph0 ? alu.i_alu_dst : r_dst;

    assign w_inv   = (w_op == OP_SUB) | (w_op == OP_CMP);
    assign w_arith = (w_op == OP_ADD) | w_inv;
    assign w_cin   = w_ph0 ? w_inv : r_carry;
    assign w_c_eff = w_inv ? ~alu.i_alu_c_data : alu.i_alu_c_data;
    assign w_sum   = {1'b0, alu.i_alu_b_data} + {1'b0, w_c_eff} + {4'b0000, w_cin};
    assign w_prev  = w_ph0 ? 1'b0 : r_prev;

    always_comb begin
        w_nib = 4'h0;
        case (w_op)
            OP_ADD, OP_SUB, OP_CMP: w_nib = w_sum[3:0];
            OP_AND:  w_nib = alu.i_alu_b_data & alu.i_alu_c_data;
            OP_OR:   w_nib = alu.i_alu_b_data | alu.i_alu_c_data;
            OP_XOR:  w_nib = alu.i_alu_b_data ^ alu.i_alu_c_data;
            OP_ANDN: w_nib = alu.i_alu_b_data & ~alu.i_alu_c_data;
            OP_SHL:  w_nib = {alu.i_alu_b_data[2:0], w_prev};
            default: w_nib = 4'h0;
        endcase
    end

    assign w_zacc = (w_ph0 ? 1'b1 : r_zacc) & (w_nib == 4'h0);
    assign w_cout = w_arith ? w_sum[4] : ((w_op == OP_SHL) ? alu.i_alu_b_data[3] : 1'b0);

    always_ff @(posedge i_alu_gck) begin
        if (i_alu_rst) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = BUSY;
            BUSY:    if (r_phase == 2'd3) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_alu_gck) begin
        if (i_alu_rst) begin
            r_phase  <= 2'd0;
            r_op     <= OP_ADD;
            r_dst    <= 3'd0;
            r_carry  <= 1'b0;
            r_prev   <= 1'b0;
            r_zacc   <= 1'b0;
            r_result <= 16'h0000;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_phase <= r_phase + 2'd1;
            r_done  <= w_active & (r_phase == 2'd3);
            if (w_accept) begin
                r_op  <= alu.i_alu_op;
                r_dst <= alu.i_alu_dst;
            end
            if (w_active) begin
                r_carry  <= w_sum[4];
                r_prev   <= alu.i_alu_b_data[3];
                r_zacc   <= w_zacc;
                r_result <= {w_nib, r_result[15:4]};
                if (r_phase == 2'd3) begin
                    r_flag_z <= w_zacc;
                    r_flag_c <= w_cout;
                end
            end
        end
    end

    assign alu.o_alu_op_rdy = w_ph0;
    assign alu.o_alu_a      = w_dst;
    assign alu.o_alu_a_vld  = w_active & ~i_alu_rst & (w_op != OP_CMP) & (w_dst != 3'd0);
    assign alu.o_alu_a_data = w_nib;
    assign alu.o_alu_done   = r_done;
    assign alu.o_alu_result = r_result;
    assign alu.o_alu_flag_z = r_flag_z;
    assign alu.o_alu_flag_c = r_flag_c;
endmodule
